// File: rtl/switch_mcu_pkg.sv
// Shared types and constants for the switch MCU fetch/execute sequencer.
package switch_mcu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 4;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    StBoot,
    StFetch,
    StExec,
    StNext
  } state_e;

endpackage

// File: rtl/switch_mcu_pc_unit.sv
// PC register with +4 advance and a latched branch/jump target.
module switch_mcu_pc_unit
  import switch_mcu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        exec_en,
  input  logic        advance,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc
);

  logic [31:0] pc_q;
  logic [31:0] redir_pc_q;
  logic        redir_vld_q;

  // A later redirect within the same instruction overwrites the earlier target.
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      pc_q        <= RESET_PC;
      redir_pc_q  <= 32'h0000_0000;
      redir_vld_q <= 1'b0;
    end else if (advance) begin
      pc_q        <= redir_vld_q ? redir_pc_q : pc_q + 32'd4;
      redir_vld_q <= 1'b0;
    end else if (exec_en && redirect) begin
      redir_pc_q  <= redirect_pc & 32'hFFFF_FFFC;
      redir_vld_q <= 1'b1;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/switch_mcu_fetch_seq.sv
// Multi-cycle fetch/execute sequencer: owns the PC, fetches over req/ack, paces execute.
module switch_mcu_fetch_seq
  import switch_mcu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned EXEC_CYCLES = 4
) (
  input  logic               in_clk,
  input  logic               in_rst,
  output logic               out_imem_req,
  output logic [31:0]        out_imem_addr,
  input  logic               in_imem_ack,
  input  logic [INSTR_W-1:0] in_imem_rdata,
  input  logic               in_stall,
  input  logic               in_redirect,
  input  logic [31:0]        in_redirect_pc,
  output logic [31:0]        out_pc_reg,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_instr_vld,
  output logic [CNT_W-1:0]   out_cycle_cnt
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(EXEC_CYCLES - 1);

  state_e      state_q;
  logic [31:0] pc;

  switch_mcu_pc_unit #(
    .RESET_PC (RESET_PC)
  ) u_pc_unit (
    .in_clk      (in_clk),
    .in_rst      (in_rst),
    .exec_en     (state_q == StExec),
    .advance     (state_q == StNext),
    .redirect    (in_redirect),
    .redirect_pc (in_redirect_pc),
    .pc          (pc)
  );

  assign out_imem_addr = pc;
  assign out_pc_reg    = pc;

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q       <= StBoot;
      out_imem_req  <= 1'b0;
      out_instr     <= NOP_INSTR;
      out_instr_vld <= 1'b0;
      out_cycle_cnt <= '0;
    end else begin
      unique case (state_q)
        StBoot: begin
          state_q      <= StFetch;
          out_imem_req <= 1'b1;
        end
        StFetch: begin
          if (in_imem_ack) begin
            state_q       <= StExec;
            out_imem_req  <= 1'b0;
            out_instr     <= in_imem_rdata;
            out_instr_vld <= 1'b1;
            out_cycle_cnt <= '0;
          end
        end
        StExec: begin
          if (!in_stall) begin
            if (out_cycle_cnt == LastCnt) begin
              state_q       <= StNext;
              out_instr_vld <= 1'b0;
              out_cycle_cnt <= '0;
            end else begin
              out_cycle_cnt <= out_cycle_cnt + 1'b1;
            end
          end
        end
        StNext: begin
          state_q      <= StFetch;
          out_imem_req <= 1'b1;
        end
        default: state_q <= StBoot;
      endcase
    end
  end

endmodule
